mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage between the execute (act) stage and the writeback stage of the pipelined NAND CPU.
- Consumes the act-pass bundle plus ALU result and memory operands. Drives a variable-latency data-memory req/ack port.
- Produces the registered writeback bundle: valid, reg write/addr/data, ps write/data.
- Stalls upstream while a memory access is outstanding. Aborts hung accesses via timeout.

Parameters:
- DATA_W, 16, width of register data, memory data and ALU result
- ADDR_W, 16, data-memory address width
- MEM_TIMEOUT, 255, cycles in WAIT before an access is abandoned (1..2^16-1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_mem_access  in  1  instruction accesses data memory
- in_mem_write  in  1  1=store, 0=load (meaningful only with in_mem_access)
- in_mem_addr  in  ADDR_W  memory address
- in_store_data  in  DATA_W  store data
- in_alu_result  in  DATA_W  result for non-load writeback
- in_reg_write  in  1  destination register write enable
- in_reg_addr  in  4  destination register
- in_ps_write  in  1  predicate/status bit write enable
- in_ps_data  in  1  predicate/status value
- stall_out  out  1  upstream must hold in_* stable
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion (one-cycle pulse)
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- wb_valid  out  1  writeback bundle valid
- wb_reg_write  out  1  writeback reg enable
- wb_reg_addr  out  4  writeback reg address
- wb_reg_data  out  DATA_W  writeback reg data
- wb_ps_write  out  1  writeback ps enable
- wb_ps_data  out  1  writeback ps value
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, timeout counter=0.
  - All outputs registered to 0, including mem_err.
  - Reset during WAIT abandons the access: mem_req=0 after that edge, no writeback issued.
- FSM states: IDLE, WAIT.
- stall_out = (state==WAIT), combinational from state only.
- in_* sampled only in IDLE. mem_ack/mem_rdata sampled only in WAIT; an ack in IDLE is ignored.
- IDLE, in_valid=1, in_mem_access=0:
  - Retire at the next edge: wb_valid=1.
  - wb_reg_write, wb_reg_addr, wb_ps_write and wb_ps_data copy the corresponding in_* signals.
  - wb_reg_data=in_alu_result.
  - Latency 1 cycle, throughput 1 per cycle.
- IDLE, in_valid=1, in_mem_access=1:
  - At the next edge: state=WAIT, mem_req=1, mem_we=in_mem_write, mem_addr=in_mem_addr, mem_wdata=in_store_data.
  - Latch reg/ps controls and in_alu_result internally. Counter=0.
  - wb_valid=0 that cycle.
- WAIT:
  - mem_req/mem_we/mem_addr/mem_wdata held stable until completion.
  - Counter increments each cycle without ack.
- WAIT, mem_ack=1 (checked before timeout; ack wins if both occur in the same cycle):
  - At the next edge: state=IDLE, mem_req=0, wb_valid=1 with the latched controls.
  - wb_reg_data=mem_rdata for a load, latched alu_result for a store.
  - A store's reg_write passes through unmodified.
- WAIT, counter==MEM_TIMEOUT-1 and no ack:
  - At the next edge: state=IDLE, mem_req=0, mem_err=1 (sticky until rst).
  - wb_valid=1 with wb_reg_write=0 and wb_ps_write=0, so the instruction retires without architectural effect.
- Minimum memory-op occupancy: accept edge, then ≥1 WAIT cycle, then the retire edge. Next instruction accepted in the cycle after the ack cycle.
- in_valid=0 in IDLE: wb_valid=0, wb_reg_write=0, wb_ps_write=0 at the next edge. Other wb fields hold their previous values.
- wb_valid is a one-cycle pulse per retired instruction. No instruction is dropped or duplicated.
- No internal arithmetic beyond the counter. The counter saturates and never wraps.

Test Plan:
- ALU pass-through: in_valid=1, mem_access=0, reg_write=1, reg_addr=4'h7, alu_result=16'hBEEF, ps_write=1, ps_data=1 -> next cycle wb_valid=1, wb_reg_addr=7, wb_reg_data=BEEF, wb_ps_data=1; stall_out stays 0. Back-to-back stream of 4 such ops -> 4 consecutive wb pulses.
- Load with 3-cycle latency: addr=16'h0040, reg_addr=3; ack 3 cycles after mem_req rises, rdata=16'h1234 -> mem_req held with addr 0040; stall_out=1 throughout WAIT; wb_valid one cycle after ack with wb_reg_data=1234, wb_reg_addr=3.
- Store: mem_write=1, addr=16'h0100, store_data=16'hA5A5, reg_write=0; ack after 1 cycle -> mem_we=1, wdata=A5A5 stable until ack; wb_valid=1 with wb_reg_write=0.
- Timeout: MEM_TIMEOUT=8, load with no ack -> after 8 WAIT cycles mem_req=0, mem_err=1, wb_valid=1 with reg_write=0 and ps_write=0; mem_err stays 1 until rst.
- Spurious ack: mem_ack=1 while IDLE -> no wb_valid, no state change. Ack and timeout in the same cycle -> normal completion, mem_err stays 0.
- Reset mid-access: rst=1 during WAIT -> after that edge mem_req=0, stall_out=0, wb_valid=0; a later ack is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage of the pipelined NAND CPU: retires ALU ops in one cycle and
// runs loads/stores over a variable-latency req/ack port, with a timeout that abandons hung accesses.
module mem_access_stage #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_access,
    input  logic              in_mem_write,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_reg_write,
    input  logic [3:0]        in_reg_addr,
    input  logic              in_ps_write,
    input  logic              in_ps_data,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [3:0]        wb_reg_addr,
    output logic [DATA_W-1:0] wb_reg_data,
    output logic              wb_ps_write,
    output logic              wb_ps_data,
    output logic              mem_err
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic                mem_req_q, mem_we_q, mem_err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                wb_valid_q, wb_reg_write_q, wb_ps_write_q, wb_ps_data_q;
    logic [3:0]          wb_reg_addr_q;
    logic [DATA_W-1:0]   wb_reg_data_q;
    // Controls of the in-flight memory op, replayed at retire
    logic                lat_store_q, lat_reg_write_q, lat_ps_write_q, lat_ps_data_q;
    logic [3:0]          lat_reg_addr_q;
    logic [DATA_W-1:0]   lat_alu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_err_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_reg_addr_q   <= '0;
            wb_reg_data_q   <= '0;
            wb_ps_write_q   <= 1'b0;
            wb_ps_data_q    <= 1'b0;
            lat_store_q     <= 1'b0;
            lat_reg_write_q <= 1'b0;
            lat_reg_addr_q  <= '0;
            lat_alu_q       <= '0;
            lat_ps_write_q  <= 1'b0;
            lat_ps_data_q   <= 1'b0;
        end else begin
            // wb_valid is a pulse; data fields hold unless a retire overwrites them
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_ps_write_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_mem_access) begin
                        state_q         <= WAIT;
                        cnt_q           <= '0;
                        mem_req_q       <= 1'b1;
                        mem_we_q        <= in_mem_write;
                        mem_addr_q      <= in_mem_addr;
                        mem_wdata_q     <= in_store_data;
                        lat_store_q     <= in_mem_write;
                        lat_reg_write_q <= in_reg_write;
                        lat_reg_addr_q  <= in_reg_addr;
                        lat_alu_q       <= in_alu_result;
                        lat_ps_write_q  <= in_ps_write;
                        lat_ps_data_q   <= in_ps_data;
                    end else if (in_valid) begin
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= in_reg_write;
                        wb_reg_addr_q  <= in_reg_addr;
                        wb_reg_data_q  <= in_alu_result;
                        wb_ps_write_q  <= in_ps_write;
                        wb_ps_data_q   <= in_ps_data;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_q        <= IDLE;
                        mem_req_q      <= 1'b0;
                        mem_we_q       <= 1'b0;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= lat_reg_write_q;
                        wb_reg_addr_q  <= lat_reg_addr_q;
                        wb_reg_data_q  <= lat_store_q ? lat_alu_q : mem_rdata;
                        wb_ps_write_q  <= lat_ps_write_q;
                        wb_ps_data_q   <= lat_ps_data_q;
                    end else if (cnt_q == TMO_LAST) begin
                        // Abandoned access still retires, but with no architectural effect
                        state_q       <= IDLE;
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        mem_err_q     <= 1'b1;
                        wb_valid_q    <= 1'b1;
                        wb_reg_addr_q <= lat_reg_addr_q;
                        wb_reg_data_q <= lat_alu_q;
                        wb_ps_data_q  <= lat_ps_data_q;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out    = (state_q == WAIT);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_err      = mem_err_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_reg_addr  = wb_reg_addr_q;
    assign wb_reg_data  = wb_reg_data_q;
    assign wb_ps_write  = wb_ps_write_q;
    assign wb_ps_data   = wb_ps_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue holds expected writebacks,
// a negedge monitor pops and compares every wb_valid pulse.
module tb_mem_access_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 0, in_mem_access = 0, in_mem_write = 0;
    logic [15:0] in_mem_addr = 0, in_store_data = 0, in_alu_result = 0;
    logic        in_reg_write = 0, in_ps_write = 0, in_ps_data = 0;
    logic [3:0]  in_reg_addr = 0;
    logic        stall_out, mem_req, mem_we, mem_ack = 0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic        wb_valid, wb_reg_write, wb_ps_write, wb_ps_data, mem_err;
    logic [3:0]  wb_reg_addr;
    logic [15:0] wb_reg_data;

    int checks = 0, errors = 0;

    typedef struct packed {
        logic        tmo;
        logic        rw;
        logic [3:0]  ra;
        logic [15:0] rd;
        logic        pw;
        logic        pd;
    } wb_t;
    wb_t sb[$];

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem_access(in_mem_access), .in_mem_write(in_mem_write),
        .in_mem_addr(in_mem_addr), .in_store_data(in_store_data), .in_alu_result(in_alu_result),
        .in_reg_write(in_reg_write), .in_reg_addr(in_reg_addr),
        .in_ps_write(in_ps_write), .in_ps_data(in_ps_data),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr),
        .wb_reg_data(wb_reg_data), .wb_ps_write(wb_ps_write), .wb_ps_data(wb_ps_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic acc, input logic we,
                         input logic [15:0] addr, input logic [15:0] sd, input logic [15:0] alu,
                         input logic rw, input logic [3:0] ra, input logic pw, input logic pd);
        in_valid = v; in_mem_access = acc; in_mem_write = we;
        in_mem_addr = addr; in_store_data = sd; in_alu_result = alu;
        in_reg_write = rw; in_reg_addr = ra; in_ps_write = pw; in_ps_data = pd;
    endtask

    task automatic push(input logic tmo, input logic rw, input logic [3:0] ra,
                        input logic [15:0] rd, input logic pw, input logic pd);
        wb_t e;
        e = '{tmo: tmo, rw: rw, ra: ra, rd: rd, pw: pw, pd: pd};
        sb.push_back(e);
    endtask

    // Timed-out retires only promise zero write enables; other fields are not compared
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                if (e.tmo)
                    chk("wb_timeout_we", {30'd0, wb_reg_write, wb_ps_write}, 32'd0);
                else
                    chk("wb_bundle", {9'd0, wb_reg_write, wb_reg_addr, wb_reg_data, wb_ps_write, wb_ps_data},
                        {9'd0, e.rw, e.ra, e.rd, e.pw, e.pd});
            end
        end
    end

    initial begin
        // Reset state
        step(); step();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        chk("rst_stall", 32'(stall_out), 0);
        chk("rst_wb_data", 32'(wb_reg_data), 0);
        rst = 1'b0;

        // ALU pass-through, then 4 back-to-back
        drive(1, 0, 0, 16'h0, 16'h0, 16'hBEEF, 1, 4'h7, 1, 1);
        push(0, 1, 4'h7, 16'hBEEF, 1, 1);
        step();
        chk("alu_wb_valid", 32'(wb_valid), 1);
        chk("alu_stall", 32'(stall_out), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 16'h0, 16'h0, 16'h1000 + 16'(i), 1, 4'(i + 1), 1, i[0]);
            push(0, 1, 4'(i + 1), 16'h1000 + 16'(i), 1, i[0]);
            step();
            chk("b2b_wb_valid", 32'(wb_valid), 1);
            chk("b2b_stall", 32'(stall_out), 0);
        end
        drive(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 4'h0, 0, 0);
        step();
        chk("idle_wb_valid", 32'(wb_valid), 0);
        chk("idle_wb_rw", 32'(wb_reg_write), 0);

        // Load, ack sampled at the third edge after mem_req rises
        drive(1, 1, 0, 16'h0040, 16'h0, 16'h5555, 1, 4'h3, 0, 0);
        push(0, 1, 4'h3, 16'h1234, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_req", 32'(mem_req), 1);
            chk("ld_addr", 32'(mem_addr), 32'h0040);
            chk("ld_we", 32'(mem_we), 0);
            chk("ld_stall", 32'(stall_out), 1);
            chk("ld_wb_valid", 32'(wb_valid), 0);
        end
        mem_ack = 1; mem_rdata = 16'h1234;
        step();
        mem_ack = 0; in_valid = 0;
        chk("ld_done_req", 32'(mem_req), 0);
        chk("ld_done_stall", 32'(stall_out), 0);
        chk("ld_done_wb_valid", 32'(wb_valid), 1);
        step();
        chk("ld_pulse_end", 32'(wb_valid), 0);

        // Store, ack after one WAIT cycle
        drive(1, 1, 1, 16'h0100, 16'hA5A5, 16'h0F0F, 0, 4'h5, 1, 0);
        push(0, 0, 4'h5, 16'h0F0F, 1, 0);
        step();
        chk("st_we", 32'(mem_we), 1);
        chk("st_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("st_addr", 32'(mem_addr), 32'h0100);
        mem_ack = 1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 0; in_valid = 0;
        chk("st_done_req", 32'(mem_req), 0);
        chk("st_wb_rw", 32'(wb_reg_write), 0);

        // Spurious ack in IDLE
        mem_ack = 1; mem_rdata = 16'hFFFF;
        step();
        mem_ack = 0;
        chk("spur_wb_valid", 32'(wb_valid), 0);
        chk("spur_stall", 32'(stall_out), 0);
        chk("spur_req", 32'(mem_req), 0);

        // Ack arrives in the very cycle the timeout would fire
        drive(1, 1, 0, 16'h0300, 16'h0, 16'h0, 1, 4'hA, 1, 1);
        push(0, 1, 4'hA, 16'hC0DE, 1, 1);
        for (int i = 0; i < 8; i++) step();
        chk("race_req_held", 32'(mem_req), 1);
        mem_ack = 1; mem_rdata = 16'hC0DE;
        step();
        mem_ack = 0; in_valid = 0;
        chk("race_req", 32'(mem_req), 0);
        chk("race_err", 32'(mem_err), 0);
        chk("race_wb_valid", 32'(wb_valid), 1);

        // Timeout: 8 WAIT cycles, then abandoned
        drive(1, 1, 0, 16'h0200, 16'h0, 16'h7777, 1, 4'h9, 1, 1);
        push(1, 0, 4'h9, 16'h7777, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("tmo_req_held", 32'(mem_req), 1);
            chk("tmo_err_early", 32'(mem_err), 0);
        end
        step();
        in_valid = 0;
        chk("tmo_req", 32'(mem_req), 0);
        chk("tmo_err", 32'(mem_err), 1);
        chk("tmo_stall", 32'(stall_out), 0);
        chk("tmo_wb_valid", 32'(wb_valid), 1);
        step(); step(); step();
        chk("tmo_err_sticky", 32'(mem_err), 1);

        // Reset in the middle of an access
        drive(1, 1, 0, 16'h0400, 16'h0, 16'h0, 1, 4'h2, 0, 0);
        step(); step();
        chk("mid_req_pre", 32'(mem_req), 1);
        rst = 1;
        step();
        chk("mid_req", 32'(mem_req), 0);
        chk("mid_stall", 32'(stall_out), 0);
        chk("mid_wb_valid", 32'(wb_valid), 0);
        chk("mid_err_clr", 32'(mem_err), 0);
        rst = 0; in_valid = 0;
        mem_ack = 1; mem_rdata = 16'h9999;
        step();
        mem_ack = 0;
        chk("mid_late_ack", 32'(wb_valid), 0);
        chk("mid_late_stall", 32'(stall_out), 0);
        step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
